l1c_mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares the single CPU-wrapper memory master port between the instruction cache (read-only line fills) and the data cache (line fills, single-word write-through stores, uncached single reads). It sits between the two L1 controllers and the AXI master interface. It serializes transactions with round-robin fairness, sequences the AR/R and AW/W/B channels, and flags memory-side protocol violations.

---
 rtl/l1c_mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_l1c_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1c_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : l1c_mem_arbiter
// Brief    : Round-robin arbiter sharing one AXI-style master port between the
//            instruction-cache and data-cache controllers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module l1c_mem_arbiter #(
    parameter int LINE_BEATS = 4,
    parameter int OFS_W      = $clog2(LINE_BEATS * 4)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_burst,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_burst,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_done,
    output logic [31:0] s_rdata,
    output logic        m_arvalid,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arlen,
    input  logic        m_arready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    output logic        m_rready,
    output logic        m_awvalid,
    output logic [31:0] m_awaddr,
    input  logic        m_awready,
    output logic        m_wvalid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        proto_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;

    localparam logic [3:0] C_BURST_LEN = 4'(LINE_BEATS - 1);

    logic [2:0]  r_state;
    logic        r_side_d;
    logic        r_last_d;
    logic        r_gnt_i;
    logic        r_gnt_d;
    logic        r_arvalid;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_wlast;
    logic        r_rready;
    logic        r_bready;
    logic        r_aw_ok;
    logic        r_w_ok;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [3:0]  r_arlen;
    logic [3:0]  r_beat;
    logic        r_proto_err;

    logic        w_pick_d;
    logic        w_burst;
    logic [31:0] w_raw_addr;
    logic [31:0] w_addr;
    logic        w_rd_beat;
    logic        w_rd_last;
    logic        w_wr_done;
    logic        w_aw_acc;
    logic        w_w_acc;

    // On a tie, the side that was not served last wins.
    assign w_pick_d   = d_req & (~i_req | ~r_last_d);
    assign w_burst    = w_pick_d ? (d_burst & ~d_write) : i_burst;
    assign w_raw_addr = w_pick_d ? d_addr : i_addr;
    assign w_addr     = w_burst ? {w_raw_addr[31:OFS_W], {OFS_W{1'b0}}} : w_raw_addr;

    assign w_rd_beat  = (r_state == S_R) & m_rvalid;
    assign w_rd_last  = w_rd_beat & m_rlast;
    assign w_wr_done  = (r_state == S_B) & m_bvalid;
    assign w_aw_acc   = r_aw_ok | (r_awvalid & m_awready);
    assign w_w_acc    = r_w_ok  | (r_wvalid  & m_wready);

    assign i_gnt      = r_gnt_i;
    assign d_gnt      = r_gnt_d;
    assign i_rvalid   = w_rd_beat & ~r_side_d;
    assign d_rvalid   = w_rd_beat &  r_side_d;
    assign i_done     = w_rd_last & ~r_side_d;
    assign d_done     = (w_rd_last & r_side_d) | w_wr_done;
    assign s_rdata    = w_rd_beat ? m_rdata : 32'h0;

    assign m_arvalid  = r_arvalid;
    assign m_araddr   = r_addr;
    assign m_arlen    = r_arlen;
    assign m_rready   = r_rready;
    assign m_awvalid  = r_awvalid;
    assign m_awaddr   = r_addr;
    assign m_wvalid   = r_wvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_wlast    = r_wlast;
    assign m_bready   = r_bready;
    assign proto_err  = r_proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_side_d    <= 1'b0;
            r_last_d    <= 1'b0;
            r_gnt_i     <= 1'b0;
            r_gnt_d     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_rready    <= 1'b0;
            r_bready    <= 1'b0;
            r_aw_ok     <= 1'b0;
            r_w_ok      <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'h0;
            r_arlen     <= 4'h0;
            r_beat      <= 4'h0;
            r_proto_err <= 1'b0;
        end else begin
            // Violations are flagged but never block completion.
            if ((m_rvalid & (r_state != S_R)) | (m_bvalid & (r_state != S_B)) |
                (w_rd_last & (r_beat != r_arlen)))
                r_proto_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_req | d_req) begin
                        r_side_d <= w_pick_d;
                        r_gnt_d  <= w_pick_d;
                        r_gnt_i  <= ~w_pick_d;
                        r_addr   <= w_addr;
                        r_arlen  <= w_burst ? C_BURST_LEN : 4'h0;
                        r_beat   <= 4'h0;
                        r_aw_ok  <= 1'b0;
                        r_w_ok   <= 1'b0;
                        if (w_pick_d & d_write) begin
                            r_wdata   <= d_wdata;
                            r_wstrb   <= d_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_wlast   <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (m_rvalid) begin
                        r_beat <= r_beat + 4'd1;
                        if (m_rlast) begin
                            r_rready <= 1'b0;
                            r_last_d <= r_side_d;
                            r_gnt_i  <= 1'b0;
                            r_gnt_d  <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_WR: begin
                    if (r_awvalid & m_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_ok   <= 1'b1;
                    end
                    if (r_wvalid & m_wready) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_w_ok   <= 1'b1;
                    end
                    if (w_aw_acc & w_w_acc) begin
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end
                end
                S_B: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        r_last_d <= 1'b1;
                        r_gnt_d  <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l1c_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_l1c_mem_arbiter
// Brief    : Directed self-checking bench for l1c_mem_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_l1c_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, i_burst = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_gnt, i_rvalid, i_done;
    logic        d_req = 1'b0, d_write = 1'b0, d_burst = 1'b0;
    logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic        d_gnt, d_rvalid, d_done;
    logic [31:0] s_rdata;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [3:0]  m_arlen, m_wstrb;
    logic        m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        proto_err;

    int n_chk = 0;
    int n_err = 0;

    l1c_mem_arbiter #(.LINE_BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_burst(d_burst),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
        .s_rdata(s_rdata),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Entered one cycle after the grant edge; serves AR then nbeats read beats.
    task automatic do_read(input logic exp_d, input logic [31:0] exp_addr,
                           input logic [3:0] exp_len, input int nbeats,
                           input logic [31:0] base, input string tag);
        chk({tag, "_gnt"}, {30'h0, i_gnt, d_gnt}, exp_d ? 32'h1 : 32'h2);
        chk({tag, "_arvalid"}, {31'h0, m_arvalid}, 32'h1);
        chk({tag, "_araddr"}, m_araddr, exp_addr);
        chk({tag, "_arlen"}, {28'h0, m_arlen}, {28'h0, exp_len});
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk({tag, "_ar_drop"}, {30'h0, m_arvalid, m_rready}, 32'h1);
        for (int k = 0; k < nbeats; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(k);
            m_rlast  = (k == nbeats - 1);
            #1;
            chk({tag, "_rvalid"}, {30'h0, i_rvalid, d_rvalid}, exp_d ? 32'h1 : 32'h2);
            chk({tag, "_rdata"}, s_rdata, base + 32'(k));
            chk({tag, "_done"}, {30'h0, i_done, d_done},
                (k == nbeats - 1) ? (exp_d ? 32'h1 : 32'h2) : 32'h0);
            chk({tag, "_gnt_hold"}, {30'h0, i_gnt, d_gnt}, exp_d ? 32'h1 : 32'h2);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rdata  = 32'h0;
        chk({tag, "_idle_gap"}, {30'h0, i_gnt, d_gnt}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
        chk("rst_valids", {26'h0, m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready}, 32'h0);
        chk("rst_addr", m_araddr | m_awaddr | m_wdata, 32'h0);
        chk("rst_misc", {23'h0, proto_err, m_arlen, m_wstrb}, 32'h0);
        tick();
        rst = 1'b0;

        // Single instruction line fill
        i_req = 1'b1; i_addr = 32'h0000_1234; i_burst = 1'b1;
        #1;
        chk("fill_pre_gnt", {31'h0, i_gnt}, 32'h0);
        tick();
        do_read(1'b0, 32'h0000_1230, 4'd3, 4, 32'hA0, "ifill");
        i_req = 1'b0;
        chk("ifill_err", {31'h0, proto_err}, 32'h0);

        // Simultaneous requests alternate D, I, D, I starting after reset
        do_reset();
        i_req = 1'b1; i_addr = 32'h3000_001C; i_burst = 1'b1;
        d_req = 1'b1; d_addr = 32'h2000_0044; d_burst = 1'b1; d_write = 1'b0;
        tick();
        do_read(1'b1, 32'h2000_0040, 4'd3, 4, 32'h100, "rr_d1");
        tick();
        do_read(1'b0, 32'h3000_0010, 4'd3, 4, 32'h200, "rr_i1");
        tick();
        do_read(1'b1, 32'h2000_0040, 4'd3, 4, 32'h300, "rr_d2");
        tick();
        do_read(1'b0, 32'h3000_0010, 4'd3, 4, 32'h400, "rr_i2");
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Write-through store with staggered channel acceptance
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h8000_0008; d_burst = 1'b1;
        d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        tick();
        chk("st_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
        chk("st_valids", {29'h0, m_awvalid, m_wvalid, m_wlast}, 32'h7);
        chk("st_awaddr", m_awaddr, 32'h8000_0008);
        chk("st_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("st_wstrb", {28'h0, m_wstrb}, 32'h3);
        chk("st_no_ar", {31'h0, m_arvalid}, 32'h0);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        chk("st_c1", {30'h0, m_awvalid, m_wvalid}, 32'h1);
        tick();
        chk("st_c2", {30'h0, m_awvalid, m_wvalid}, 32'h1);
        tick();
        chk("st_c3", {30'h0, m_awvalid, m_wvalid}, 32'h1);
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        chk("st_c4", {29'h0, m_awvalid, m_wvalid, m_bready}, 32'h1);
        chk("st_c4_done", {31'h0, d_done}, 32'h0);
        tick();
        m_bvalid = 1'b1;
        #1;
        chk("st_done", {29'h0, d_done, d_gnt, m_bready}, 32'h7);
        tick();
        m_bvalid = 1'b0;
        d_req = 1'b0; d_write = 1'b0; d_burst = 1'b0;
        chk("st_after", {29'h0, d_gnt, m_bready, proto_err}, 32'h0);

        // Uncached single read
        d_req = 1'b1; d_addr = 32'h1000_0004; d_burst = 1'b0;
        tick();
        do_read(1'b1, 32'h1000_0004, 4'd0, 1, 32'h5555_0000, "unc");
        d_req = 1'b0;
        chk("unc_err", {31'h0, proto_err}, 32'h0);

        // Early rlast, then stray bvalid; proto_err sticks
        i_req = 1'b1; i_addr = 32'h0000_0048; i_burst = 1'b1;
        tick();
        do_read(1'b0, 32'h0000_0040, 4'd3, 2, 32'h600, "early");
        i_req = 1'b0;
        chk("early_err", {31'h0, proto_err}, 32'h1);
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        chk("stray_b_err", {31'h0, proto_err}, 32'h1);
        d_req = 1'b1; d_addr = 32'h1000_0008; d_burst = 1'b0;
        tick();
        do_read(1'b1, 32'h1000_0008, 4'd0, 1, 32'h700, "post_err");
        d_req = 1'b0;
        chk("post_err_sticky", {31'h0, proto_err}, 32'h1);

        // Reset in the middle of a fill
        do_reset();
        chk("rst2_err", {31'h0, proto_err}, 32'h0);
        i_req = 1'b1; i_addr = 32'h5000_0024; i_burst = 1'b1;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1'b1; m_rdata = 32'h800 + 32'(k); m_rlast = 1'b0;
            tick();
        end
        rst = 1'b1;
        m_rdata = 32'h0000_0FFF;
        #1;
        chk("mid_rst_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
        chk("mid_rst_rd", {28'h0, i_rvalid, i_done, m_rready, m_arvalid}, 32'h0);
        chk("mid_rst_sdata", s_rdata, 32'h0);
        chk("mid_rst_misc", {31'h0, proto_err} | m_araddr, 32'h0);
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        tick();
        rst = 1'b0;
        #1;
        chk("rel_idle", {31'h0, i_gnt}, 32'h0);
        tick();
        do_read(1'b0, 32'h5000_0020, 4'd3, 4, 32'h900, "refill");
        i_req = 1'b0;
        chk("refill_err", {31'h0, proto_err}, 32'h0);

        // Stray beats outside their states
        tick();
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        chk("stray_b_only", {31'h0, proto_err}, 32'h1);
        do_reset();
        m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;
        chk("stray_r_only", {31'h0, proto_err}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
